// File: rtl/clock_time_ctrl.sv
// Six-digit HH:MM:SS clock with RUN/SET control driven by three raw push buttons.
// The time registers feed a registered seven-segment encoder; decimal points are fixed separators.
module clock_time_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sw_mode,
    input  logic        i_sw_pos,
    input  logic        i_sw_inc,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic [1:0]  o_setting_mode,
    output logic [1:0]  o_setting_position,
    output logic        o_blink
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [1:0]      pos_q, pos_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      hour_q, hour_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
    logic            blink_q, blink_d;
    logic [41:0]     seg_q, seg_d;
    logic [2:0]      sync1_q, sync2_q, dly_q;
    logic [1:0]      warm_q, warm_d;
    logic [2:0]      pulse;
    logic            modeP, posP, incP;

    function automatic logic [5:0] wrapInc(input logic [5:0] v, input logic [5:0] maxV);
        return (v == maxV) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h7E;
            4'd1:    seg7 = 7'h30;
            4'd2:    seg7 = 7'h6D;
            4'd3:    seg7 = 7'h79;
            4'd4:    seg7 = 7'h33;
            4'd5:    seg7 = 7'h5B;
            4'd6:    seg7 = 7'h5F;
            4'd7:    seg7 = 7'h70;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h7B;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic logic [13:0] digitPair(input logic [5:0] v);
        return {seg7(4'(v / 6'd10)), seg7(4'(v % 6'd10))};
    endfunction

    // Pulses stay masked until the synchroniser has refilled after reset, so a
    // button held through reset release does not look like a fresh press.
    assign pulse = sync2_q & ~dly_q & {3{warm_q == 2'd3}};
    assign modeP = pulse[2];
    assign posP  = pulse[1];
    assign incP  = pulse[0];
    assign warm_d = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            dly_q      <= 3'b000;
            warm_q     <= 2'd0;
            mode_q     <= MODE_RUN;
            pos_q      <= 2'd0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hour_q     <= 6'd0;
            presc_q    <= '0;
            blinkCnt_q <= '0;
            blink_q    <= 1'b0;
            seg_q      <= {6{7'h7E}};
        end else begin
            sync1_q    <= {i_sw_mode, i_sw_pos, i_sw_inc};
            sync2_q    <= sync1_q;
            dly_q      <= sync2_q;
            warm_q     <= warm_d;
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            presc_q    <= presc_d;
            blinkCnt_q <= blinkCnt_d;
            blink_q    <= blink_d;
            seg_q      <= seg_d;
        end
    end

    // A mode pulse outranks everything; in SET an inc uses the old position
    // before a simultaneous pos pulse advances it.
    always_comb begin
        mode_d     = mode_q;
        pos_d      = pos_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        presc_d    = presc_q;
        blinkCnt_d = blinkCnt_q;
        blink_d    = blink_q;
        seg_d      = {digitPair(hour_q), digitPair(min_q), digitPair(sec_q)};

        if (modeP) begin
            blink_d = 1'b0;
            if (mode_q == MODE_RUN) begin
                mode_d     = MODE_SET;
                pos_d      = 2'd0;
                blinkCnt_d = '0;
            end else begin
                mode_d  = MODE_RUN;
                presc_d = '0;
            end
        end else if (mode_q == MODE_SET) begin
            if (incP) begin
                case (pos_q)
                    2'd0:    sec_d  = wrapInc(sec_q, 6'd59);
                    2'd1:    min_d  = wrapInc(min_q, 6'd59);
                    default: hour_d = wrapInc(hour_q, 6'd23);
                endcase
                blinkCnt_d = '0;
                blink_d    = 1'b0;
            end else if (blinkCnt_q == BW'(BLINK_HALF - 1)) begin
                blinkCnt_d = '0;
                blink_d    = ~blink_q;
            end else begin
                blinkCnt_d = blinkCnt_q + BW'(1);
            end
            if (posP) begin
                pos_d = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
            end
        end else if (presc_q == PW'(CLK_HZ - 1)) begin
            presc_d = '0;
            sec_d   = wrapInc(sec_q, 6'd59);
            if (sec_q == 6'd59) begin
                min_d = wrapInc(min_q, 6'd59);
                if (min_q == 6'd59) begin
                    hour_d = wrapInc(hour_q, 6'd23);
                end
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    assign o_six_digit_seg    = seg_q;
    assign o_six_dp           = 6'b010100;
    assign o_setting_mode     = {1'b0, mode_q};
    assign o_setting_position = pos_q;
    assign o_blink            = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with CLK_HZ = 8 and BLINK_HALF = 2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_time_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sw_mode = 1'b0;
    logic        i_sw_pos = 1'b0;
    logic        i_sw_inc = 1'b0;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic [1:0]  o_setting_mode;
    logic [1:0]  o_setting_position;
    logic        o_blink;

    int assertCount = 0;
    int failCount = 0;
    logic expBlink;

    localparam logic [41:0] SEG_000000 = {7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};

    clock_time_ctrl #(
        .CLK_HZ     (8),
        .BLINK_HALF (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_sw_mode          (i_sw_mode),
        .i_sw_pos           (i_sw_pos),
        .i_sw_inc           (i_sw_inc),
        .o_six_digit_seg    (o_six_digit_seg),
        .o_six_dp           (o_six_dp),
        .o_setting_mode     (o_setting_mode),
        .o_setting_position (o_setting_position),
        .o_blink            (o_blink)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [41:0] obs, input logic [41:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Raise the chosen buttons and return on the falling edge after the third rising edge.
    task automatic applyStimulus(input logic m, input logic p, input logic n);
        i_sw_mode = m;
        i_sw_pos  = p;
        i_sw_inc  = n;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyRelease();
        i_sw_mode = 1'b0;
        i_sw_pos  = 1'b0;
        i_sw_inc  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pressTimes(input logic p, input logic n, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, p, n);
            applyRelease();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_seg"},  o_six_digit_seg, SEG_000000);
        checkOutput({tag, "_dp"},   42'(o_six_dp), 42'(6'b010100));
        checkOutput({tag, "_mode"}, 42'(o_setting_mode), 42'd0);
        checkOutput({tag, "_pos"},  42'(o_setting_position), 42'd0);
        checkOutput({tag, "_blink"}, 42'(o_blink), 42'd0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");

        rst = 1'b0;
        repeat (480) @(posedge clk);
        @(negedge clk);
        checkOutput("run_00_00_59", o_six_digit_seg, {7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h5B, 7'h7B});
        @(posedge clk);
        @(negedge clk);
        checkOutput("run_00_01_00_low", 42'(o_six_digit_seg[27:0]), 42'({7'h7E, 7'h30, 7'h7E, 7'h7E}));
        checkOutput("run_00_01_00", o_six_digit_seg, {7'h7E, 7'h7E, 7'h7E, 7'h30, 7'h7E, 7'h7E});
        checkOutput("run_blink", 42'(o_blink), 42'd0);

        // Mode and inc together in RUN: only the mode change happens.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("enter_set_mode", 42'(o_setting_mode), 42'd1);
        checkOutput("enter_set_pos", 42'(o_setting_position), 42'd0);
        checkOutput("enter_set_blink", 42'(o_blink), 42'd0);
        checkOutput("enter_set_time", o_six_digit_seg, {7'h7E, 7'h7E, 7'h7E, 7'h30, 7'h7E, 7'h7E});
        applyRelease();
        checkOutput("blink_after_release", 42'(o_blink), 42'd1);

        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            expBlink = 1'b1 ^ logic'(((k + 1) / 2) % 2);
            checkOutput($sformatf("blink_hold_%0d", k), 42'(o_blink), 42'(expBlink));
        end
        checkOutput("set_time_frozen", o_six_digit_seg, {7'h7E, 7'h7E, 7'h7E, 7'h30, 7'h7E, 7'h7E});

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("inc_forces_blink0", 42'(o_blink), 42'd0);
        applyRelease();
        checkOutput("inc_sec", o_six_digit_seg, {7'h7E, 7'h7E, 7'h7E, 7'h30, 7'h7E, 7'h30});

        pressTimes(1'b1, 1'b0, 1);
        checkOutput("pos_1", 42'(o_setting_position), 42'd1);
        pressTimes(1'b1, 1'b0, 1);
        checkOutput("pos_2", 42'(o_setting_position), 42'd2);
        pressTimes(1'b0, 1'b1, 25);
        checkOutput("hour_25_incs_pos", 42'(o_setting_position), 42'd2);
        checkOutput("hour_25_incs_time", o_six_digit_seg, {7'h7E, 7'h30, 7'h7E, 7'h30, 7'h7E, 7'h30});

        pressTimes(1'b1, 1'b1, 1);
        checkOutput("pos_inc_same_pos", 42'(o_setting_position), 42'd0);
        checkOutput("pos_inc_same_time", o_six_digit_seg, {7'h7E, 7'h6D, 7'h7E, 7'h30, 7'h7E, 7'h30});

        pressTimes(1'b0, 1'b1, 58);
        checkOutput("sec_59", o_six_digit_seg, {7'h7E, 7'h6D, 7'h7E, 7'h30, 7'h5B, 7'h7B});
        pressTimes(1'b0, 1'b1, 1);
        checkOutput("sec_wrap_no_carry", o_six_digit_seg, {7'h7E, 7'h6D, 7'h7E, 7'h30, 7'h7E, 7'h7E});
        pressTimes(1'b0, 1'b1, 59);
        pressTimes(1'b1, 1'b0, 1);
        pressTimes(1'b0, 1'b1, 58);
        pressTimes(1'b1, 1'b0, 1);
        pressTimes(1'b0, 1'b1, 21);
        checkOutput("preload_23_59_59", o_six_digit_seg, {7'h6D, 7'h79, 7'h5B, 7'h7B, 7'h5B, 7'h7B});

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("back_to_run_mode", 42'(o_setting_mode), 42'd0);
        checkOutput("back_to_run_pos", 42'(o_setting_position), 42'd2);
        checkOutput("back_to_run_blink", 42'(o_blink), 42'd0);
        applyRelease();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("before_midnight", o_six_digit_seg, {7'h6D, 7'h79, 7'h5B, 7'h7B, 7'h5B, 7'h7B});
        @(posedge clk);
        @(negedge clk);
        checkOutput("midnight_rollover", o_six_digit_seg, SEG_000000);

        // Pos and inc in RUN must be ignored.
        pressTimes(1'b1, 1'b1, 1);
        checkOutput("run_pos_ignored", 42'(o_setting_position), 42'd2);
        checkOutput("run_inc_ignored", o_six_digit_seg, SEG_000000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reenter_set", 42'(o_setting_mode), 42'd1);
        applyRelease();
        pressTimes(1'b1, 1'b0, 1);
        checkOutput("set_pos_1", 42'(o_setting_position), 42'd1);

        // Asynchronous reset in SET with the mode button held through release.
        i_sw_mode = 1'b1;
        #1 rst = 1'b1;
        #1 checkResetOutputs("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("held_button_no_pulse", 42'(o_setting_mode), 42'd0);
        applyRelease();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("press_after_reset", 42'(o_setting_mode), 42'd1);
        applyRelease();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
CLOCK_TIME_CTRL -- requirements
Module: clock_time_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk cycles per 1 s tick; SHALL be >= 4.
REQ-002 Parameter BLINK_HALF, default 12500000, clk cycles per o_blink half-period in SET.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_sw_mode  input  1  raw level button; each rising edge toggles RUN/SET.
REQ-006 i_sw_pos  input  1  raw level button; each rising edge advances the field selected for setting.
REQ-007 i_sw_inc  input  1  raw level button; each rising edge increments the selected field.
REQ-008 o_six_digit_seg  output  42  seven-segment patterns: [6:0] sec ones, [13:7] sec tens, [20:14] min ones, [27:21] min tens, [34:28] hour ones, [41:35] hour tens.
REQ-009 o_six_dp  output  6  decimal points, active-high, same digit order as REQ-008.
REQ-010 o_setting_mode  output  2  0 = RUN, 1 = SET; 2 and 3 SHALL never be driven.
REQ-011 o_setting_position  output  2  0 = sec, 1 = min, 2 = hour; 3 SHALL never be driven.
REQ-012 o_blink  output  1  blink phase for the selected field in SET.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser plus a delay flop; one action pulse per 0->1 transition, producing the state update on the 3rd rising clk edge after the input rises.
REQ-014 Time held as binary sec 0-59, min 0-59, hour 0-23.
REQ-015 RUN: prescaler counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0 and sec increments.
REQ-016 RUN carries: sec 59->0 increments min; min 59->0 increments hour; 23:59:59 -> 00:00:00 in one tick.
REQ-017 RUN->SET on mode pulse: position := 0, blink counter := 0, o_blink := 0, prescaler frozen.
REQ-018 SET->RUN on mode pulse: prescaler := 0, o_blink := 0, position kept; first sec tick occurs CLK_HZ cycles later.
REQ-019 SET, pos pulse: position 0->1->2->0.
REQ-020 SET, inc pulse: selected field +1 with own-field wrap (sec/min 59->0, hour 23->0), no carry into other fields; blink counter := 0, o_blink := 0.
REQ-021 RUN: pos and inc pulses SHALL be ignored.
REQ-022 Same-cycle mode pulse with pos or inc pulse: mode action only; the others are discarded.
REQ-023 Same-cycle pos and inc pulses in SET: inc applies to the old position, then position advances.
REQ-024 SET: blink counter counts 0..BLINK_HALF-1; at BLINK_HALF-1 it wraps and o_blink toggles. RUN: o_blink held 0.
REQ-025 Digit split: tens = value/10, ones = value%10, each encoded as {a,b,c,d,e,f,g} (bit6 = a), active-high: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B (hex).
REQ-026 o_six_digit_seg SHALL be registered, reflecting the time one clk cycle after a time update.
REQ-027 o_six_dp SHALL be constant 6'b010100 (separators after hour ones and min ones).
REQ-028 o_setting_mode, o_setting_position and o_blink SHALL be registered outputs of the control state.

Reset
REQ-029 While rst = 1: time 00:00:00, prescaler 0, blink counter 0, mode RUN, position 0, o_blink 0, synchroniser flops 0.
REQ-030 While rst = 1: o_six_digit_seg = {6{7'h7E}}, o_six_dp = 6'b010100, o_setting_mode = 0, o_setting_position = 0.
REQ-031 Reset asserted mid-operation (either mode) SHALL apply REQ-029/030 immediately; a button held high through reset release SHALL NOT generate a pulse.

Verification (CLK_HZ = 8, BLINK_HALF = 2)
REQ-032 Release rst, run 8*60 cycles -> 00:01:00; o_six_digit_seg[27:0] = {7E,30,7E,7E} (min tens, min ones, sec tens, sec ones).
REQ-033 Preload 23:59:59 via SET, return to RUN, wait 8 cycles -> 00:00:00, all digits 7E.
REQ-034 Mode pulse, pos pulse twice, inc pulse 25 times -> hour = 1, min and sec unchanged, o_setting_position = 2.
REQ-035 In SET, hold 20 cycles with no input -> o_blink toggles every 2 cycles, time frozen; inc pulse forces o_blink = 0.
REQ-036 Mode and inc rise on the same cycle in RUN -> mode = SET, time unchanged.
REQ-037 Assert rst while in SET at position 1 -> all outputs at REQ-030 values asynchronously.
